// File: rtl/i2c_pkg.sv
// Shared types and constants for the two-requester I2C master arbiter.
// Holds the FSM encoding, default sizes and the valid/ready handshake helper.
package i2c_pkg;

  localparam int DATA_DEPTH_DEFAULT = 8;
  localparam int NUM_REQ_FIXED      = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_XFER  = 2'd2
  } state_t;

  // A transfer on any valid/ready channel happens on a cycle with both high.
  function automatic logic hs(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick; on a tie the requester that was
// not granted last time wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    if (req == 2'b11) begin
      gnt_idx = ~last_gnt;
    end else begin
      gnt_idx = req[1];
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one I2C master between two requesters: round-robin command accept,
// address/byte-count issue, then data channels routed to the granted requester.
module i2c_master_arbiter
  import i2c_pkg::*;
#(
  parameter int DATA_DEPTH = DATA_DEPTH_DEFAULT,
  parameter int NUM_REQ    = NUM_REQ_FIXED
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [NUM_REQ*2*DATA_DEPTH-1:0] i_cmd_bits,
  input  logic [NUM_REQ-1:0]              i_cmd_valid,
  output logic [NUM_REQ-1:0]              o_cmd_ready,
  input  logic [NUM_REQ*DATA_DEPTH-1:0]   i_wr_bits,
  input  logic [NUM_REQ-1:0]              i_wr_valid,
  output logic [NUM_REQ-1:0]              o_wr_ready,
  output logic [DATA_DEPTH-1:0]           o_rd_bits,
  output logic [NUM_REQ-1:0]              o_rd_valid,
  input  logic [NUM_REQ-1:0]              i_rd_ready,
  output logic [NUM_REQ-1:0]              o_done,
  output logic [NUM_REQ-1:0]              o_nak,
  output logic                            o_m_start,
  output logic [DATA_DEPTH-1:0]           o_m_addr_bits,
  output logic                            o_m_addr_valid,
  input  logic                            i_m_addr_ready,
  output logic [DATA_DEPTH-1:0]           o_m_nbytes_bits,
  output logic                            o_m_nbytes_valid,
  input  logic                            i_m_nbytes_ready,
  output logic [DATA_DEPTH-1:0]           o_m_wr_bits,
  output logic                            o_m_wr_valid,
  input  logic                            i_m_wr_ready,
  input  logic [DATA_DEPTH-1:0]           i_m_rd_bits,
  input  logic                            i_m_rd_valid,
  output logic                            o_m_rd_ready,
  input  logic                            i_m_nak,
  input  logic                            i_m_done
);

  state_t                  state_reg, state_next;
  logic                    win_reg, win_next;
  logic                    last_gnt_reg, last_gnt_next;
  logic [DATA_DEPTH-1:0]   addr_reg, addr_next;
  logic [DATA_DEPTH-1:0]   nbytes_reg, nbytes_next;
  logic                    addr_pend_reg, addr_pend_next;
  logic                    nbytes_pend_reg, nbytes_pend_next;
  logic                    start_reg, start_next;

  logic [2*DATA_DEPTH-1:0] cmd_arr [NUM_REQ];
  logic [DATA_DEPTH-1:0]   wr_arr  [NUM_REQ];
  logic [2*DATA_DEPTH-1:0] cmd_sel;
  logic                    gnt_valid;
  logic                    gnt_idx;
  logic                    active;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign cmd_arr[gi] = i_cmd_bits[gi*2*DATA_DEPTH +: 2*DATA_DEPTH];
    assign wr_arr[gi]  = i_wr_bits[gi*DATA_DEPTH +: DATA_DEPTH];
  end

  rr_arbiter2 u_arb (
    .req       (i_cmd_valid[1:0]),
    .last_gnt  (last_gnt_reg),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  assign cmd_sel = cmd_arr[gnt_idx];
  assign active  = (state_reg != ST_IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg       <= ST_IDLE;
      win_reg         <= 1'b0;
      last_gnt_reg    <= 1'b1;
      addr_reg        <= '0;
      nbytes_reg      <= '0;
      addr_pend_reg   <= 1'b0;
      nbytes_pend_reg <= 1'b0;
      start_reg       <= 1'b0;
    end else begin
      state_reg       <= state_next;
      win_reg         <= win_next;
      last_gnt_reg    <= last_gnt_next;
      addr_reg        <= addr_next;
      nbytes_reg      <= nbytes_next;
      addr_pend_reg   <= addr_pend_next;
      nbytes_pend_reg <= nbytes_pend_next;
      start_reg       <= start_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    win_next         = win_reg;
    last_gnt_next    = last_gnt_reg;
    addr_next        = addr_reg;
    nbytes_next      = nbytes_reg;
    addr_pend_next   = addr_pend_reg;
    nbytes_pend_next = nbytes_pend_reg;
    start_next       = 1'b0;
    o_cmd_ready      = '0;

    case (state_reg)
      ST_IDLE: begin
        // Ready is held low while reset is applied so every output reads 0.
        if (gnt_valid && !i_rst) begin
          o_cmd_ready[gnt_idx] = 1'b1;
          win_next             = gnt_idx;
          addr_next            = cmd_sel[DATA_DEPTH-1:0];
          nbytes_next          = cmd_sel[2*DATA_DEPTH-1:DATA_DEPTH];
          addr_pend_next       = 1'b1;
          nbytes_pend_next     = 1'b1;
          start_next           = 1'b1;
          state_next           = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (hs(o_m_addr_valid, i_m_addr_ready)) begin
          addr_pend_next = 1'b0;
        end
        if (hs(o_m_nbytes_valid, i_m_nbytes_ready)) begin
          nbytes_pend_next = 1'b0;
        end
        if (!addr_pend_next && !nbytes_pend_next) begin
          state_next = ST_XFER;
        end
      end
      default: begin
      end
    endcase

    // Master completion wins over anything still pending in ISSUE.
    if (active && i_m_done) begin
      state_next       = ST_IDLE;
      last_gnt_next    = win_reg;
      addr_pend_next   = 1'b0;
      nbytes_pend_next = 1'b0;
      start_next       = 1'b0;
    end
  end

  assign o_m_start        = start_reg;
  assign o_m_addr_bits    = addr_reg;
  assign o_m_nbytes_bits  = nbytes_reg;
  assign o_m_addr_valid   = (state_reg == ST_ISSUE) && addr_pend_reg;
  assign o_m_nbytes_valid = (state_reg == ST_ISSUE) && nbytes_pend_reg;

  assign o_m_wr_valid = active && i_wr_valid[win_reg];
  assign o_m_wr_bits  = active ? wr_arr[win_reg] : '0;
  assign o_m_rd_ready = active && i_rd_ready[win_reg];
  assign o_rd_bits    = active ? i_m_rd_bits : '0;

  always_comb begin
    o_wr_ready = '0;
    o_rd_valid = '0;
    o_done     = '0;
    o_nak      = '0;
    if (active) begin
      o_wr_ready[win_reg] = i_m_wr_ready;
      o_rd_valid[win_reg] = i_m_rd_valid;
      o_done[win_reg]     = i_m_done;
      o_nak[win_reg]      = i_m_done && i_m_nak;
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter: expected commands and read bytes are
// queued when driven and checked when the arbiter presents them.
module tb_i2c_master_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_cmd_bits = '0;
  logic [1:0]  i_cmd_valid = '0;
  logic [1:0]  o_cmd_ready;
  logic [15:0] i_wr_bits = '0;
  logic [1:0]  i_wr_valid = '0;
  logic [1:0]  o_wr_ready;
  logic [7:0]  o_rd_bits;
  logic [1:0]  o_rd_valid;
  logic [1:0]  i_rd_ready = '0;
  logic [1:0]  o_done;
  logic [1:0]  o_nak;
  logic        o_m_start;
  logic [7:0]  o_m_addr_bits;
  logic        o_m_addr_valid;
  logic        i_m_addr_ready = 1'b0;
  logic [7:0]  o_m_nbytes_bits;
  logic        o_m_nbytes_valid;
  logic        i_m_nbytes_ready = 1'b0;
  logic [7:0]  o_m_wr_bits;
  logic        o_m_wr_valid;
  logic        i_m_wr_ready = 1'b0;
  logic [7:0]  i_m_rd_bits = '0;
  logic        i_m_rd_valid = 1'b0;
  logic        o_m_rd_ready;
  logic        i_m_nak = 1'b0;
  logic        i_m_done = 1'b0;

  i2c_master_arbiter #(.DATA_DEPTH(8), .NUM_REQ(2)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_cmd_bits(i_cmd_bits), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_wr_bits(i_wr_bits), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .o_rd_bits(o_rd_bits), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
    .o_done(o_done), .o_nak(o_nak), .o_m_start(o_m_start),
    .o_m_addr_bits(o_m_addr_bits), .o_m_addr_valid(o_m_addr_valid),
    .i_m_addr_ready(i_m_addr_ready),
    .o_m_nbytes_bits(o_m_nbytes_bits), .o_m_nbytes_valid(o_m_nbytes_valid),
    .i_m_nbytes_ready(i_m_nbytes_ready),
    .o_m_wr_bits(o_m_wr_bits), .o_m_wr_valid(o_m_wr_valid), .i_m_wr_ready(i_m_wr_ready),
    .i_m_rd_bits(i_m_rd_bits), .i_m_rd_valid(i_m_rd_valid), .o_m_rd_ready(o_m_rd_ready),
    .i_m_nak(i_m_nak), .i_m_done(i_m_done)
  );

  always #5 i_clk = ~i_clk;

  logic [46:0] all_out;
  assign all_out = {o_cmd_ready, o_wr_ready, o_rd_bits, o_rd_valid, o_done, o_nak,
                    o_m_start, o_m_addr_bits, o_m_addr_valid, o_m_nbytes_bits,
                    o_m_nbytes_valid, o_m_wr_bits, o_m_wr_valid, o_m_rd_ready};

  typedef struct {
    logic       win;
    logic [7:0] addr;
    logic [7:0] nbytes;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_rd[$];
  logic [7:0] m_q[$];
  logic       cur_win = 1'b0;
  int         compared = 0;
  int         mismatched = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    i_rst = 1'b1;
    i_cmd_valid = '0; i_wr_valid = '0; i_rd_ready = '0;
    i_m_addr_ready = 0; i_m_nbytes_ready = 0; i_m_wr_ready = 0;
    i_m_rd_valid = 0; i_m_done = 0; i_m_nak = 0;
    tick(); tick();
    chk("reset_outputs", all_out, 0);
    i_rst = 1'b0;
  endtask

  // Drive a command set in the current IDLE cycle and walk it through ISSUE.
  task automatic issue(input logic [1:0] mask, input logic [7:0] a0, input logic [7:0] n0,
                       input logic [7:0] a1, input logic [7:0] n1, input logic exp_win);
    exp_t e;
    i_cmd_bits  = {n1, a1, n0, a0};
    i_cmd_valid = mask;
    e.win    = exp_win;
    e.addr   = exp_win ? a1 : a0;
    e.nbytes = exp_win ? n1 : n0;
    sb.push_back(e);
    #1;
    chk("cmd_ready", o_cmd_ready, 2'b01 << exp_win);
    tick();
    i_cmd_valid[exp_win] = 1'b0;
    i_cmd_bits[exp_win*16 +: 16] = 16'hDEAD;
    i_m_addr_ready = 1'b1; i_m_nbytes_ready = 1'b0;
    #1;
    chk("m_start", o_m_start, 1);
    chk("issue_cmd_ready", o_cmd_ready, 0);
    chk("addr_valid", o_m_addr_valid, 1);
    chk("nbytes_valid", o_m_nbytes_valid, 1);
    chk("sb_nonempty", sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      cur_win = e.win;
      chk("m_addr", o_m_addr_bits, e.addr);
      chk("m_nbytes", o_m_nbytes_bits, e.nbytes);
    end
    tick();
    i_m_addr_ready = 1'b0; i_m_nbytes_ready = 1'b1;
    #1;
    chk("m_start_once", o_m_start, 0);
    chk("addr_dropped", o_m_addr_valid, 0);
    chk("nbytes_held", o_m_nbytes_valid, 1);
    tick();
    i_m_nbytes_ready = 1'b0;
    #1;
    chk("nbytes_dropped", o_m_nbytes_valid, 0);
    chk("xfer_no_start", o_m_start, 0);
  endtask

  task automatic wr_route();
    i_wr_bits = 16'h2211; i_wr_valid = 2'b11; i_m_wr_ready = 1'b1;
    #1;
    chk("wr_ready_route", o_wr_ready, 2'b01 << cur_win);
    chk("m_wr_bits", o_m_wr_bits, cur_win ? 8'h22 : 8'h11);
    chk("m_wr_valid", o_m_wr_valid, 1);
    #1;
    i_wr_valid = '0; i_m_wr_ready = 1'b0;
  endtask

  task automatic read_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    exp_rd.push_back(b0); exp_rd.push_back(b1); exp_rd.push_back(b2);
    m_q.push_back(b0); m_q.push_back(b1); m_q.push_back(b2);
    for (int cyc = 0; cyc < 30 && exp_rd.size() > 0; cyc++) begin
      tick();
      i_m_rd_valid = (m_q.size() > 0);
      i_m_rd_bits  = (m_q.size() > 0) ? m_q[0] : 8'h00;
      i_rd_ready[cur_win]  = cyc[0];
      i_rd_ready[!cur_win] = 1'b1;
      #1;
      chk("loser_rd_valid", o_rd_valid[!cur_win], 0);
      if (o_rd_valid[cur_win] && i_rd_ready[cur_win]) begin
        chk("m_rd_ready", o_m_rd_ready, 1);
        chk("rd_byte", o_rd_bits, exp_rd.pop_front());
        void'(m_q.pop_front());
      end
    end
    chk("rd_all_received", exp_rd.size(), 0);
    tick();
    i_m_rd_valid = 1'b0; i_rd_ready = '0;
    exp_rd.delete(); m_q.delete();
  endtask

  task automatic finish_txn(input logic nak);
    tick();
    i_m_done = 1'b1; i_m_nak = nak;
    #1;
    chk("done", o_done, 2'b01 << cur_win);
    chk("nak", o_nak, nak ? (2'b01 << cur_win) : 2'b00);
    tick();
    i_m_done = 1'b0; i_m_nak = 1'b0;
    #1;
    chk("done_single", o_done, 0);
    chk("nak_single", o_nak, 0);
    chk("idle_rd_ready", o_m_rd_ready, 0);
  endtask

  initial begin
    apply_reset();
    // req0 alone, read three bytes
    issue(2'b01, 8'h4E, 8'd2, 8'h00, 8'h00, 1'b0);
    wr_route();
    read_bytes(8'hA1, 8'hB2, 8'hC3);
    finish_txn(1'b0);
    // tie after reset goes to req0, then alternation 0,1,0,1
    apply_reset();
    issue(2'b11, 8'h10, 8'd1, 8'h20, 8'd4, 1'b0);
    wr_route();
    finish_txn(1'b0);
    issue(2'b10, 8'h10, 8'd1, 8'h20, 8'd4, 1'b1);
    wr_route();
    finish_txn(1'b0);
    issue(2'b11, 8'h31, 8'd3, 8'h42, 8'd5, 1'b0);
    finish_txn(1'b0);
    issue(2'b11, 8'h31, 8'd3, 8'h42, 8'd5, 1'b1);
    finish_txn(1'b1);
    // reset in the middle of XFER
    issue(2'b10, 8'h00, 8'd0, 8'h55, 8'd7, 1'b1);
    i_m_rd_valid = 1'b1; i_m_rd_bits = 8'h99; i_rd_ready = 2'b11;
    i_wr_valid = 2'b11; i_m_wr_ready = 1'b1;
    #1;
    i_rst = 1'b1; i_m_done = 1'b1;
    #1;
    chk("rst_async_outputs", all_out, 0);
    tick();
    chk("rst_edge_outputs", all_out, 0);
    chk("rst_no_done", o_done, 0);
    i_m_done = 1'b0; i_m_rd_valid = 1'b0; i_rd_ready = '0;
    i_wr_valid = '0; i_m_wr_ready = 1'b0;
    i_rst = 1'b0;
    tick();
    issue(2'b10, 8'h00, 8'd0, 8'h66, 8'd9, 1'b1);
    wr_route();
    finish_txn(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_master_arbiter.md
I2C_MASTER_ARBITER -- requirements
Module: i2c_master_arbiter

Interface
REQ-001 Parameter DATA_DEPTH, default 8, width of addr/nbytes/data bytes.
REQ-002 Parameter NUM_REQ, default 2, number of requesters; fixed at 2 in this revision.
REQ-003 i_clk  in  1  single clock; all logic on posedge.
REQ-004 i_rst  in  1  asynchronous, active-high reset.
REQ-005 i_cmd_bits  in  2*2*DATA_DEPTH  per requester n at [n*2*DD +: 2*DD]: {nbytes, addr}.
REQ-006 i_cmd_valid  in  2  requester n has a transaction to issue.
REQ-007 o_cmd_ready  out  2  one-cycle command accept to winner.
REQ-008 i_wr_bits  in  2*DATA_DEPTH  per-requester write byte.
REQ-009 i_wr_valid  in  2  per-requester write valid.
REQ-010 o_wr_ready  out  2  write ready, routed to granted requester only.
REQ-011 o_rd_bits  out  DATA_DEPTH  read byte, broadcast.
REQ-012 o_rd_valid  out  2  read valid, granted requester only.
REQ-013 i_rd_ready  in  2  per-requester read ready.
REQ-014 o_done  out  2  one-cycle end-of-transaction pulse to granted requester.
REQ-015 o_nak  out  2  NAK status, valid only with o_done.
REQ-016 o_m_start  out  1  one-cycle start pulse to I2C master.
REQ-017 o_m_addr_bits / o_m_addr_valid  out  DATA_DEPTH / 1  master address channel.
REQ-018 i_m_addr_ready  in  1  master address ready.
REQ-019 o_m_nbytes_bits / o_m_nbytes_valid  out  DATA_DEPTH / 1  master byte-count channel.
REQ-020 i_m_nbytes_ready  in  1  master byte-count ready.
REQ-021 o_m_wr_bits / o_m_wr_valid, i_m_wr_ready  out/out/in  DATA_DEPTH/1/1  master write channel.
REQ-022 i_m_rd_bits / i_m_rd_valid, o_m_rd_ready  in/in/out  DATA_DEPTH/1/1  master read channel.
REQ-023 i_m_nak, i_m_done  in  1 each  master end-of-transaction pulse and its NAK flag.

Function
REQ-024 FSM states IDLE, ISSUE, XFER; a handshake completes on a cycle with valid&ready high.
REQ-025 IDLE: any i_cmd_valid high -> round-robin pick (requester other than last_gnt wins ties), o_cmd_ready[win]=1 same cycle, latch cmd bits and win, go ISSUE.
REQ-026 ISSUE entry cycle: o_m_start=1 for exactly one cycle.
REQ-027 ISSUE: o_m_addr_valid and o_m_nbytes_valid high with latched bits, each dropped independently after its handshake; both done -> XFER.
REQ-028 ISSUE and XFER: write/read channels combinationally muxed between winner and master; non-granted o_wr_ready/o_rd_valid=0.
REQ-029 i_m_done in ISSUE or XFER: o_done[win]=1, o_nak[win]=i_m_nak same cycle, last_gnt<=win, go IDLE; pending ISSUE valids dropped.
REQ-030 i_m_done in IDLE ignored; o_m_rd_ready=0 and all o_rd_valid=0 in IDLE.
REQ-031 i_cmd_valid deasserted or changed after accept has no effect; command latched.
REQ-032 No new command accepted before the cycle after o_done; minimum back-to-back spacing 1 idle cycle.

Reset
REQ-033 On i_rst: state IDLE, last_gnt=1 (requester 0 wins first); all outputs 0; bits outputs 0.
REQ-034 Reset mid-transaction aborts immediately; no o_done issued.

Structure
REQ-035 Package i2c_pkg: state encoding, DATA_DEPTH default, NUM_REQ, handshake helper constants.
REQ-036 Sub-module rr_arbiter2: combinational 2-way round-robin pick from request vector and last_gnt.

Verification
REQ-037 Reset, req0 cmd {nbytes=2, addr=0x4E} -> o_cmd_ready[0] cycle 0, o_m_start cycle 1, addr 0x4E, nbytes 2 on master.
REQ-038 Both requesters valid in IDLE after reset -> req0 granted, after its i_m_done req1 granted.
REQ-039 Req1 repeatedly valid with req0 -> grants alternate 0,1,0,1 over 4 transactions.
REQ-040 i_m_done with i_m_nak=1 -> o_done[win]=1, o_nak[win]=1 single cycle, loser sees 0.
REQ-041 Read 3 bytes 0xA1,0xB2,0xC3 with i_rd_ready toggling -> winner receives all three in order, loser o_rd_valid stays 0.
REQ-042 Assert i_rst during XFER -> all outputs 0 next edge, no o_done, next command accepted normally.
